comp_strg_arbiter: RTL and testbench
====================================

Name: comp_strg_arbiter

Overview:
- Round-robin arbiter and command sequencer that shares one computation-storage unit between NUM_REQ requesters.
- Accepts one command at a time over a valid/ready handshake and drives the storage command bus (en, cmd, addA/addB/addC, bidirectional DQ).
- Tracks completion (valid_out for READ, fixed latency otherwise) and returns a one-cycle response to the granted requester.
- Sits between the client blocks and the storage unit; it is the only driver of the storage command bus.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- ADDR_WIDTH, 4, storage address width.
- DATA_WIDTH, 32, storage data width.
- OP_LATENCY, 2, cycles after the ISSUE cycle before an ADD/SUB is complete; must be >= 1.
- RD_TIMEOUT, 16, READ timeout in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active high.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_cmd  in  2*NUM_REQ  packed commands: 0 READ, 1 WRITE, 2 ADD, 3 SUB.
- req_addA  in  ADDR_WIDTH*NUM_REQ  packed addA.
- req_addB  in  ADDR_WIDTH*NUM_REQ  packed addB.
- req_addC  in  ADDR_WIDTH*NUM_REQ  packed addC.
- req_wdata  in  DATA_WIDTH*NUM_REQ  packed WRITE data.
- rsp_valid  out  NUM_REQ  one-hot response strobe.
- rsp_err  out  1  error flag, qualified by any rsp_valid bit.
- rsp_data  out  DATA_WIDTH  READ data, qualified by rsp_valid.
- strg_en  out  1  storage enable.
- strg_cmd  out  2  storage command.
- strg_addA  out  ADDR_WIDTH  storage address A.
- strg_addB  out  ADDR_WIDTH  storage address B.
- strg_addC  out  ADDR_WIDTH  storage address C.
- strg_valid_out  in  1  storage READ data valid.
- strg_DQ  inout  DATA_WIDTH  storage data bus.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0, strg_en=0, strg_cmd=0, all strg_add*=0, strg_DQ=high-Z, state=IDLE, rr pointer so requester 0 has highest priority.
- States: IDLE, ISSUE, WAIT_RD, WAIT_OP, RESP.
- IDLE:
  - Select the first requester with req_valid set, scanning circularly from last_grant+1.
  - req_ready[g]=1 combinationally in that same cycle. Capture g and its cmd/addresses/wdata at the clock edge.
  - If cmd is ADD/SUB and addA==addB: skip the storage access; go to RESP with err=1.
  - Otherwise go to ISSUE. With no req_valid, stay in IDLE and keep req_ready=0.
- ISSUE (exactly 1 cycle):
  - strg_en=1; strg_cmd and strg_add* come from the captured request.
  - For WRITE, strg_DQ is driven with wdata; in every other state and command, strg_DQ is high-Z.
  - Next state: READ -> WAIT_RD; WRITE -> RESP; ADD/SUB -> WAIT_OP with counter loaded to OP_LATENCY-1.
- In every state other than ISSUE, strg_en=0 and strg_cmd/strg_add* hold their last values.
- WAIT_RD: sample strg_valid_out each cycle. When it is 1, capture strg_DQ into rsp_data and go to RESP with err=0.
- WAIT_OP: decrement the counter; go to RESP when it reaches 0, with err=0 and rsp_data=0.
- RESP (1 cycle):
  - rsp_valid[g]=1, rsp_err per the path taken; set last_grant=g; go to IDLE.
  - A new grant occurs in the following IDLE cycle at the earliest, so issues are back-to-back every >=3 cycles.
- Latency from acceptance edge T:
  - READ: en at T+1; valid_out sampled at T+2 at the earliest; rsp_valid at T+3.
  - WRITE: rsp_valid at T+2.
  - ADD/SUB: rsp_valid at T+2+OP_LATENCY.
  - Rejected ADD/SUB: rsp_valid at T+1.
- Fairness: the rr pointer advances only on RESP. A requester holding req_valid is granted within NUM_REQ grants.
- A strg_valid_out pulse outside WAIT_RD is ignored.
- Reset asserted mid-operation: next edge returns all outputs to reset values, abandons the in-flight request with no response, and releases DQ.

Optional Feature:
- Macro: COMP_STRG_ARB_TIMEOUT_EN.
- Defined: WAIT_RD counts cycles. If strg_valid_out has not arrived after RD_TIMEOUT cycles, go to RESP with rsp_err=1 and rsp_data=0.
- Not defined: WAIT_RD waits indefinitely and there is no timeout counter logic.

Test Plan:
- Reset: rst=1 for 2 cycles with req_valid=2'b11 -> req_ready=0, strg_en=0, strg_DQ=Z; after release, requester 0 is granted first.
- Contention: req0 WRITE addA=3 wdata=0xA5A5A5A5 and req1 READ addA=3, both held valid -> req0 is granted first, strg_DQ=0xA5A5A5A5 during its en cycle; then req1 is granted, and with valid_out returning 0xA5A5A5A5, rsp_valid=2'b10 and rsp_data=0xA5A5A5A5.
- ADD addA=1 addB=2 addC=5, OP_LATENCY=2, accepted at T -> strg_en=1 and strg_cmd=2 at T+1 only; rsp_valid at T+4 with rsp_err=0.
- SUB addA=addB=7 -> strg_en never asserted; rsp_valid at T+1 with rsp_err=1.
- Round-robin: req0 and req1 continuously valid with WRITE -> grants alternate 0,1,0,1 over 4 commands.
- Timeout (macro defined): READ issued and valid_out held at 0 -> rsp_err=1 and rsp_data=0 after RD_TIMEOUT=16 cycles; without the macro, no response and the FSM stays in WAIT_RD.

Source files
------------

// File: rtl/comp_strg_arbiter.sv
// rtl/comp_strg_arbiter.sv - round-robin arbiter and command sequencer for a shared computation-storage unit
// Optional READ timeout enabled by defining COMP_STRG_ARB_TIMEOUT_EN.
module comp_strg_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int OP_LATENCY = 2,
    parameter int RD_TIMEOUT = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_REQ-1:0]               req_valid_i,
    output logic [NUM_REQ-1:0]               req_ready_o,
    input  logic [2*NUM_REQ-1:0]             req_cmd_i,
    input  logic [ADDR_WIDTH*NUM_REQ-1:0]    req_addA_i,
    input  logic [ADDR_WIDTH*NUM_REQ-1:0]    req_addB_i,
    input  logic [ADDR_WIDTH*NUM_REQ-1:0]    req_addC_i,
    input  logic [DATA_WIDTH*NUM_REQ-1:0]    req_wdata_i,
    output logic [NUM_REQ-1:0]               rsp_valid_o,
    output logic                             rsp_err_o,
    output logic [DATA_WIDTH-1:0]            rsp_data_o,
    output logic                             strg_en_o,
    output logic [1:0]                       strg_cmd_o,
    output logic [ADDR_WIDTH-1:0]            strg_addA_o,
    output logic [ADDR_WIDTH-1:0]            strg_addB_o,
    output logic [ADDR_WIDTH-1:0]            strg_addC_o,
    input  logic                             strg_valid_out_i,
    inout  wire  [DATA_WIDTH-1:0]            strg_dq_io
);

    localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_MAX = (OP_LATENCY > RD_TIMEOUT) ? OP_LATENCY : RD_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [1:0] CMD_READ  = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT_RD = 3'd2,
        S_WAIT_OP = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          gnt_q, gnt_d;
    logic [IW-1:0]          last_q, last_d;
    logic [1:0]             cmd_q, cmd_d;
    logic [ADDR_WIDTH-1:0]  adda_q, adda_d;
    logic [ADDR_WIDTH-1:0]  addb_q, addb_d;
    logic [ADDR_WIDTH-1:0]  addc_q, addc_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;

    logic [1:0]             cmd_a   [NUM_REQ];
    logic [ADDR_WIDTH-1:0]  adda_a  [NUM_REQ];
    logic [ADDR_WIDTH-1:0]  addb_a  [NUM_REQ];
    logic [ADDR_WIDTH-1:0]  addc_a  [NUM_REQ];
    logic [DATA_WIDTH-1:0]  wdata_a [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign cmd_a[i]   = req_cmd_i[2*i +: 2];
        assign adda_a[i]  = req_addA_i[ADDR_WIDTH*i +: ADDR_WIDTH];
        assign addb_a[i]  = req_addB_i[ADDR_WIDTH*i +: ADDR_WIDTH];
        assign addc_a[i]  = req_addC_i[ADDR_WIDTH*i +: ADDR_WIDTH];
        assign wdata_a[i] = req_wdata_i[DATA_WIDTH*i +: DATA_WIDTH];
    end

    // Circular scan starting one past the last responded requester.
    logic          sel_valid;
    logic [IW-1:0] sel_idx;

    always_comb begin
        int            tmp;
        logic [IW-1:0] idx;
        sel_valid = 1'b0;
        sel_idx   = '0;
        tmp       = 0;
        idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            tmp = int'(last_q) + k;
            if (tmp >= NUM_REQ) begin
                tmp = tmp - NUM_REQ;
            end
            idx = IW'(tmp);
            if (!sel_valid && req_valid_i[idx]) begin
                sel_valid = 1'b1;
                sel_idx   = idx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            cmd_q   <= '0;
            adda_q  <= '0;
            addb_q  <= '0;
            addc_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cmd_q   <= cmd_d;
            adda_q  <= adda_d;
            addb_q  <= addb_d;
            addc_q  <= addc_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cmd_d   = cmd_q;
        adda_d  = adda_q;
        addb_d  = addb_q;
        addc_d  = addc_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (sel_valid) begin
                    gnt_d  = sel_idx;
                    err_d  = 1'b0;
                    data_d = '0;
                    // Arithmetic on identical operands is refused without touching storage;
                    // the storage bus keeps presenting the previous command.
                    if (cmd_a[sel_idx][1] && (adda_a[sel_idx] == addb_a[sel_idx])) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        cmd_d   = cmd_a[sel_idx];
                        adda_d  = adda_a[sel_idx];
                        addb_d  = addb_a[sel_idx];
                        addc_d  = addc_a[sel_idx];
                        wdata_d = wdata_a[sel_idx];
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (cmd_q == CMD_READ) begin
                    state_d = S_WAIT_RD;
`ifdef COMP_STRG_ARB_TIMEOUT_EN
                    cnt_d   = CW'(RD_TIMEOUT - 1);
`endif
                end else if (cmd_q == CMD_WRITE) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT_OP;
                    cnt_d   = CW'(OP_LATENCY - 1);
                end
            end
            S_WAIT_RD: begin
                if (strg_valid_out_i) begin
                    data_d  = strg_dq_io;
                    state_d = S_RESP;
                end
`ifdef COMP_STRG_ARB_TIMEOUT_EN
                else if (cnt_q == '0) begin
                    err_d   = 1'b1;
                    data_d  = '0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
`endif
            end
            S_WAIT_OP: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                last_d  = gnt_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        strg_en_o   = 1'b0;
        if (!rst_i && (state_q == S_IDLE) && sel_valid) begin
            req_ready_o[sel_idx] = 1'b1;
        end
        if (state_q == S_RESP) begin
            rsp_valid_o[gnt_q] = 1'b1;
        end
        if (state_q == S_ISSUE) begin
            strg_en_o = 1'b1;
        end
    end

    assign rsp_err_o   = err_q;
    assign rsp_data_o  = data_q;
    assign strg_cmd_o  = cmd_q;
    assign strg_addA_o = adda_q;
    assign strg_addB_o = addb_q;
    assign strg_addC_o = addc_q;
    assign strg_dq_io  = ((state_q == S_ISSUE) && (cmd_q == CMD_WRITE)) ? wdata_q : 'z;

endmodule

// File: tb/tb_comp_strg_arbiter.sv
// tb/tb_comp_strg_arbiter.sv - randomized self-checking bench for comp_strg_arbiter
module tb_comp_strg_arbiter;
    localparam int N   = 2;
    localparam int AW  = 4;
    localparam int DW  = 32;
    localparam int OPL = 2;
    localparam int RDT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready, rsp_valid;
    logic [2*N-1:0]  req_cmd = '0;
    logic [AW*N-1:0] req_a = '0, req_b = '0, req_c = '0;
    logic [DW*N-1:0] req_wd = '0;
    logic            rsp_err;
    logic [DW-1:0]   rsp_data;
    logic            strg_en;
    logic [1:0]      strg_cmd;
    logic [AW-1:0]   strg_a, strg_b, strg_c;
    logic            strg_vo = 1'b0;
    wire  [DW-1:0]   dq;
    logic            dq_oe = 1'b0;
    logic [DW-1:0]   dq_val = '0;
    assign dq = dq_oe ? dq_val : 'z;

    comp_strg_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OP_LATENCY(OPL), .RD_TIMEOUT(RDT)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_cmd_i(req_cmd), .req_addA_i(req_a), .req_addB_i(req_b), .req_addC_i(req_c),
        .req_wdata_i(req_wd),
        .rsp_valid_o(rsp_valid), .rsp_err_o(rsp_err), .rsp_data_o(rsp_data),
        .strg_en_o(strg_en), .strg_cmd_o(strg_cmd),
        .strg_addA_o(strg_a), .strg_addB_o(strg_b), .strg_addC_o(strg_c),
        .strg_valid_out_i(strg_vo), .strg_dq_io(dq)
    );

    int total = 0;
    int bad   = 0;

    logic [N-1:0]  o_ready, o_rv;
    logic          o_en, o_err;
    logic [1:0]    o_cmd;
    logic [AW-1:0] o_a;
    logic [DW-1:0] o_data, o_dq;

    // Transaction-level model: one outstanding request, timed from its acceptance cycle.
    bit            m_busy = 1'b0;
    int            m_t = 0, m_g = 0, m_last = N - 1, m_resp_t = 0;
    logic [1:0]    m_cmd = '0;
    bit            m_rej = 1'b0, m_err = 1'b0;
    logic [DW-1:0] m_data = '0;
    logic [1:0]    m_scmd = '0;
    logic [AW-1:0] m_sa = '0, m_sb = '0, m_sc = '0;
    logic [DW-1:0] m_wd = '0;
    bit            rst_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [1:0] c, input logic [AW-1:0] a,
                           input logic [AW-1:0] b, input logic [AW-1:0] cc, input logic [DW-1:0] w);
        req_cmd[2*i +: 2]  = c;
        req_a[AW*i +: AW]  = a;
        req_b[AW*i +: AW]  = b;
        req_c[AW*i +: AW]  = cc;
        req_wd[DW*i +: DW] = w;
    endtask

    // Called at posedge+1 with inputs set; samples, checks against the model, advances one clock.
    task automatic cycle();
        logic [N-1:0] exp_ready, exp_rv;
        bit           exp_en;
        int           tmp;
        #1;
        o_ready = req_ready; o_rv = rsp_valid; o_en = strg_en; o_err = rsp_err;
        o_data = rsp_data; o_cmd = strg_cmd; o_a = strg_a; o_dq = dq;
        exp_ready = '0; exp_rv = '0; exp_en = 1'b0;
        if (rst) begin
            chk("rst_ready", o_ready, '0);
            if (rst_prev) begin
                chk("rst_en", o_en, 0);
                chk("rst_rsp_valid", o_rv, '0);
                chk("rst_err", o_err, 0);
                chk("rst_data", o_data, 0);
                chk("rst_cmd", o_cmd, 0);
            end
            m_busy = 1'b0; m_last = N - 1;
            m_scmd = '0; m_sa = '0; m_sb = '0; m_sc = '0;
            rst_prev = 1'b1;
        end else begin
            rst_prev = 1'b0;
            chk("strg_cmd", strg_cmd, m_scmd);
            chk("strg_addA", strg_a, m_sa);
            chk("strg_addB", strg_b, m_sb);
            chk("strg_addC", strg_c, m_sc);
            if (m_busy) begin
                m_t++;
                exp_en = (m_t == 1) && !m_rej;
                if (exp_en && m_cmd == 2'd1) chk("dq_write", o_dq, m_wd);
                if (m_t == m_resp_t) begin
                    exp_rv[m_g] = 1'b1;
                    chk("rsp_err", o_err, m_err);
                    if (m_cmd != 2'd1 && !m_rej) chk("rsp_data", o_data, m_data);
                    m_busy = 1'b0;
                    m_last = m_g;
                end else if (m_cmd == 2'd0 && m_t >= 2 && m_resp_t < 0) begin
                    if (strg_vo) begin
                        m_resp_t = m_t + 1;
                        m_data   = dq;
                    end
`ifdef COMP_STRG_ARB_TIMEOUT_EN
                    else if (m_t == RDT + 1) begin
                        m_resp_t = m_t + 1;
                        m_err    = 1'b1;
                        m_data   = '0;
                    end
`endif
                end
            end else begin
                for (int k = 1; k <= N; k++) begin
                    tmp = (m_last + k) % N;
                    if (exp_ready == '0 && req_valid[tmp]) begin
                        exp_ready[tmp] = 1'b1;
                        m_busy = 1'b1; m_t = 0; m_g = tmp;
                        m_cmd  = req_cmd[2*tmp +: 2];
                        m_rej  = m_cmd[1] && (req_a[AW*tmp +: AW] == req_b[AW*tmp +: AW]);
                        m_err  = m_rej; m_data = '0;
                        if (!m_rej) begin
                            m_scmd = m_cmd;
                            m_sa = req_a[AW*tmp +: AW];
                            m_sb = req_b[AW*tmp +: AW];
                            m_sc = req_c[AW*tmp +: AW];
                            m_wd = req_wd[DW*tmp +: DW];
                        end
                        if (m_rej)              m_resp_t = 1;
                        else if (m_cmd == 2'd1) m_resp_t = 2;
                        else if (m_cmd == 2'd0) m_resp_t = -1;
                        else                    m_resp_t = 2 + OPL;
                    end
                end
            end
            chk("req_ready", o_ready, exp_ready);
            chk("rsp_valid", o_rv, exp_rv);
            chk("strg_en", o_en, exp_en);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand();
        bit wr_next;
        wr_next = m_busy && (m_t == 0) && !m_rej && (m_cmd == 2'd1);
        for (int i = 0; i < N; i++) begin
            if (!req_valid[i] || o_ready[i]) begin
                req_valid[i] = ($urandom_range(0, 2) != 0);
                set_req(i, 2'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
                        AW'($urandom_range(0, 3)), AW'($urandom_range(0, 15)), $urandom);
            end
        end
        strg_vo = ($urandom_range(0, 3) == 0);
        dq_oe   = strg_vo && !wr_next;
        dq_val  = $urandom;
    endtask

    initial begin
        int grants [$];
        int first_rsp;
        bit seen_err;
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = 2'b11;
        set_req(0, 2'd1, 4'd3, 4'd0, 4'd0, 32'hA5A5_A5A5);
        set_req(1, 2'd0, 4'd3, 4'd0, 4'd0, 32'h0);
        cycle();
        chk("reset_ready", o_ready, 2'b00);
        dq_oe = 1'b1; dq_val = 32'h1234_5678;
        cycle();
        chk("reset_dq_released", o_dq, 32'h1234_5678);
        chk("reset_en_low", o_en, 0);
        rst = 1'b0; dq_oe = 1'b0;

        cycle(); chk("first_grant_req0", o_ready, 2'b01);
        req_valid[0] = 1'b0;
        cycle(); chk("wr_en", o_en, 1); chk("wr_dq", o_dq, 32'hA5A5_A5A5); chk("wr_cmd", o_cmd, 1);
        cycle(); chk("wr_rsp", o_rv, 2'b01);
        cycle(); chk("second_grant_req1", o_ready, 2'b10);
        req_valid[1] = 1'b0;
        cycle(); chk("rd_en", o_en, 1); chk("rd_cmd", o_cmd, 0); chk("rd_addA", o_a, 3);
        strg_vo = 1'b1; dq_oe = 1'b1; dq_val = 32'hA5A5_A5A5;
        cycle(); chk("rd_no_rsp_yet", o_rv, 2'b00);
        strg_vo = 1'b0; dq_oe = 1'b0;
        cycle(); chk("rd_rsp", o_rv, 2'b10); chk("rd_data", o_data, 32'hA5A5_A5A5); chk("rd_err", o_err, 0);

        set_req(0, 2'd2, 4'd1, 4'd2, 4'd5, 32'h0); req_valid[0] = 1'b1;
        cycle(); chk("add_grant", o_ready, 2'b01);
        req_valid[0] = 1'b0;
        cycle(); chk("add_en", o_en, 1); chk("add_cmd", o_cmd, 2);
        cycle(); chk("add_en_once", o_en, 0); chk("add_rsp_t2", o_rv, 2'b00);
        cycle(); chk("add_rsp_t3", o_rv, 2'b00);
        cycle(); chk("add_rsp_t4", o_rv, 2'b01); chk("add_err", o_err, 0); chk("add_data", o_data, 0);

        set_req(1, 2'd3, 4'd7, 4'd7, 4'd0, 32'h0); req_valid[1] = 1'b1;
        cycle(); chk("sub_grant", o_ready, 2'b10); chk("sub_no_en", o_en, 0);
        req_valid[1] = 1'b0;
        cycle(); chk("sub_rsp", o_rv, 2'b10); chk("sub_err", o_err, 1); chk("sub_no_en2", o_en, 0);

        set_req(0, 2'd1, 4'd2, 4'd0, 4'd0, 32'h1111_0000);
        set_req(1, 2'd1, 4'd4, 4'd0, 4'd0, 32'h2222_0000);
        req_valid = 2'b11;
        for (int c = 0; c < 40 && grants.size() < 4; c++) begin
            cycle();
            if (o_ready == 2'b01) grants.push_back(0);
            if (o_ready == 2'b10) grants.push_back(1);
        end
        req_valid = 2'b00;
        chk("rr_grant_count", grants.size(), 4);
        if (grants.size() == 4) begin
            chk("rr_g0", grants[0], 0); chk("rr_g1", grants[1], 1);
            chk("rr_g2", grants[2], 0); chk("rr_g3", grants[3], 1);
        end
        for (int c = 0; c < 4; c++) cycle();

        set_req(0, 2'd0, 4'd9, 4'd0, 4'd0, 32'h0); req_valid[0] = 1'b1;
        cycle(); chk("to_grant", o_ready, 2'b01);
        req_valid[0] = 1'b0;
        first_rsp = 0; seen_err = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            cycle();
            if (o_rv != '0 && first_rsp == 0) begin
                first_rsp = i;
                seen_err  = o_err;
            end
        end
`ifdef COMP_STRG_ARB_TIMEOUT_EN
        chk("timeout_latency", first_rsp, 2 + RDT);
        chk("timeout_err", seen_err, 1);
`else
        chk("no_timeout_rsp", first_rsp, 0);
        strg_vo = 1'b1; dq_oe = 1'b1; dq_val = 32'hDEAD_BEEF;
        cycle();
        strg_vo = 1'b0; dq_oe = 1'b0;
        cycle(); chk("late_rd_rsp", o_rv, 2'b01); chk("late_rd_data", o_data, 32'hDEAD_BEEF);
`endif

        for (int c = 0; c < 1500; c++) begin
            drive_rand();
            if (c == 700) rst = 1'b1;
            cycle();
            rst = 1'b0;
        end
        req_valid = '0; strg_vo = 1'b0; dq_oe = 1'b0;
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
